// File: rtl/jtag_scan_master.sv
// jtag_scan_master: host-side JTAG driver. Walks the target TAP from
// Run-Test/Idle through Capture/Shift/Update of the IR or DR path and back,
// shifting request data out on TDI (MSB first) and collecting TDO.
// One TCK period is two i_tclk cycles: a low cycle, then a high cycle.

module jtag_scan_master #(
  parameter int REG_W = 8,
  parameter int LEN_W = $clog2(REG_W + 1)
) (
  input  logic             i_tclk,
  input  logic             i_trst_n,
  input  logic             i_start,
  input  logic             i_isIr,
  input  logic [LEN_W-1:0] i_len,
  input  logic [REG_W-1:0] i_data,
  output logic             o_busy,
  output logic             o_done,
  output logic [REG_W-1:0] o_data,
  output logic             o_tck,
  output logic             o_tms,
  output logic             o_tdi,
  input  logic             i_tdo
);

  // The slot counter must reach both the last INIT slot (5) and len-1.
  localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_HDR,
    ST_SHIFT,
    ST_EXIT,
    ST_UPD
  } state_e;

  state_e             state_q, state_d;
  logic               phase_q, phase_d;   // 0: TCK low cycle, 1: TCK high cycle
  logic [CNT_W-1:0]   cnt_q,   cnt_d;     // slot index inside the current state
  logic               is_ir_q, is_ir_d;
  logic [LEN_W-1:0]   len_q,   len_d;
  logic [REG_W-1:0]   sh_q,    sh_d;      // outgoing bits, left-aligned
  logic [REG_W-1:0]   rx_q,    rx_d;      // incoming TDO bits
  logic [REG_W-1:0]   data_q,  data_d;    // response held until next done
  logic               done_q,  done_d;

  logic [LEN_W-1:0]   len_clamp;
  logic [LEN_W-1:0]   align_sh;
  logic [REG_W-1:0]   len_mask;
  logic [CNT_W-1:0]   hdr_last;
  logic [CNT_W-1:0]   shift_last;

  // Clamp the requested length into 1..REG_W and derive alignment/mask terms.
  // NOTE: every combinational output is given a default first so that no
  // path through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    len_clamp = i_len;
    if (i_len == '0) begin
      len_clamp = LEN_W'(1);
    end else if (i_len > LEN_W'(REG_W)) begin
      len_clamp = LEN_W'(REG_W);
    end
    align_sh = LEN_W'(REG_W) - len_clamp;
    len_mask = '0;
    for (int i = 0; i < REG_W; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign hdr_last   = is_ir_q ? CNT_W'(3) : CNT_W'(2);
  assign shift_last = CNT_W'(len_q - LEN_W'(1));

  // TCK/TMS/TDI decode from the current state and slot.
  // In IDLE the accept cycle doubles as the low cycle of the first header
  // slot, so TMS follows i_start there (first header TMS is 1 for IR and DR).
  always_comb begin
    o_tms = 1'b0;
    case (state_q)
      ST_INIT:  o_tms = (cnt_q != CNT_W'(5));
      ST_IDLE:  o_tms = i_start;
      ST_HDR:   o_tms = (cnt_q == '0) || (is_ir_q && (cnt_q == CNT_W'(1)));
      ST_SHIFT: o_tms = (cnt_q == shift_last);
      ST_EXIT:  o_tms = 1'b1;
      ST_UPD:   o_tms = 1'b0;
      default:  o_tms = 1'b0;
    endcase
  end

  assign o_tck  = phase_q;
  assign o_tdi  = (state_q == ST_SHIFT) & sh_q[REG_W-1];
  assign o_busy = (state_q != ST_IDLE);
  assign o_done = done_q;
  assign o_data = data_q;

  // Next-state logic: low cycles sample TDO, high cycles advance the slot.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    is_ir_d = is_ir_q;
    len_d   = len_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    data_d  = data_q;
    done_d  = 1'b0;

    if (state_q == ST_IDLE) begin
      if (i_start) begin
        state_d = ST_HDR;
        phase_d = 1'b1;
        cnt_d   = '0;
        is_ir_d = i_isIr;
        len_d   = len_clamp;
        sh_d    = i_data << align_sh;
        rx_d    = '0;
      end
    end else if (!phase_q) begin
      // TDO is taken just before the target sees the rising TCK edge.
      phase_d = 1'b1;
      if (state_q == ST_SHIFT) begin
        rx_d = {rx_q[REG_W-2:0], i_tdo};
      end
    end else begin
      phase_d = 1'b0;
      cnt_d   = cnt_q + CNT_W'(1);
      case (state_q)
        ST_INIT: begin
          if (cnt_q == CNT_W'(5)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_HDR: begin
          if (cnt_q == hdr_last) begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
          end
        end
        ST_SHIFT: begin
          sh_d = sh_q << 1;
          if (cnt_q == shift_last) begin
            state_d = ST_EXIT;
            cnt_d   = '0;
          end
        end
        ST_EXIT: begin
          state_d = ST_UPD;
          cnt_d   = '0;
        end
        ST_UPD: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          data_d  = rx_q & len_mask;
        end
        default: begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State register; reset restarts the INIT sequence and clears the response.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge i_tclk or negedge i_trst_n) begin
    if (!i_trst_n) begin
      state_q <= ST_INIT;
      phase_q <= 1'b0;
      cnt_q   <= '0;
      is_ir_q <= 1'b0;
      len_q   <= LEN_W'(1);
      sh_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      is_ir_q <= is_ir_d;
      len_q   <= len_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_jtag_scan_master.sv
// tb_jtag_scan_master: drives jtag_scan_master against a behavioural JTAG
// target (full 16-state TAP plus IR/DR registers) and checks timing,
// TMS sequences, returned data and target register updates.

module tb_jtag_scan_master;

  localparam int REG_W = 8;
  localparam int LEN_W = $clog2(REG_W + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             is_ir = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [REG_W-1:0] data = '0;
  logic             busy, done, tck, tms, tdi, tdo;
  logic [REG_W-1:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  jtag_scan_master #(.REG_W(REG_W)) dut (
    .i_tclk  (clk),
    .i_trst_n(rst_n),
    .i_start (start),
    .i_isIr  (is_ir),
    .i_len   (len),
    .i_data  (data),
    .o_busy  (busy),
    .o_done  (done),
    .o_data  (rdata),
    .o_tck   (tck),
    .o_tms   (tms),
    .o_tdi   (tdi),
    .i_tdo   (tdo)
  );

  // ---------------- behavioural JTAG target ----------------
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_e;

  tap_e        tap_q;
  logic [7:0]  tgt_sh, tgt_ir, tgt_dr;
  int          tgt_len = 8;
  logic [7:0]  cap_val = 8'h00;
  logic [7:0]  tgt_mask;
  logic [31:0] tms_log;
  int          slot_cnt;

  assign tgt_mask = 8'hFF >> (8 - tgt_len);
  assign tdo      = tgt_sh[tgt_len-1];

  function automatic tap_e tap_next(tap_e s, logic m);
    case (s)
      TLR:     return m ? TLR    : RTI;
      RTI:     return m ? SEL_DR : RTI;
      SEL_DR:  return m ? SEL_IR : CAP_DR;
      CAP_DR:  return m ? EX1_DR : SH_DR;
      SH_DR:   return m ? EX1_DR : SH_DR;
      EX1_DR:  return m ? UPD_DR : PAU_DR;
      PAU_DR:  return m ? EX2_DR : PAU_DR;
      EX2_DR:  return m ? UPD_DR : SH_DR;
      UPD_DR:  return m ? SEL_DR : RTI;
      SEL_IR:  return m ? TLR    : CAP_IR;
      CAP_IR:  return m ? EX1_IR : SH_IR;
      SH_IR:   return m ? EX1_IR : SH_IR;
      EX1_IR:  return m ? UPD_IR : PAU_IR;
      PAU_IR:  return m ? EX2_IR : PAU_IR;
      EX2_IR:  return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  // Target TAP: acts on each rising TCK and logs the TMS seen per slot.
  always @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      tap_q    <= TLR;
      tgt_sh   <= 8'h00;
      tgt_ir   <= 8'h00;
      tgt_dr   <= 8'h00;
      tms_log  <= '0;
      slot_cnt <= 0;
    end else begin
      tms_log  <= {tms_log[30:0], tms};
      slot_cnt <= slot_cnt + 1;
      case (tap_q)
        CAP_DR, CAP_IR: tgt_sh <= cap_val & tgt_mask;
        SH_DR, SH_IR:   tgt_sh <= {tgt_sh[6:0], tdi} & tgt_mask;
        UPD_IR:         tgt_ir <= tgt_sh;
        UPD_DR:         tgt_dr <= tgt_sh;
        default: ;
      endcase
      tap_q <= tap_next(tap_q, tms);
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present a request at a negedge; returns after the accepting edge.
  task automatic start_scan(input logic ir, input logic [LEN_W-1:0] l, input logic [7:0] d,
                            input logic [7:0] cap, input int tl, output int s0);
    cap_val = cap;
    tgt_len = tl;
    is_ir   = ir;
    len     = l;
    data    = d;
    s0      = slot_cnt;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Wait (bounded) for done, counting cycles from the accept cycle, then
  // check everything visible in the done cycle. Returns at that negedge.
  task automatic finish_scan(input string name, input int s0, input logic ir, input int exp_lat,
                             input int exp_slots, input logic [31:0] exp_tms,
                             input logic [7:0] exp_data, input logic [7:0] exp_tgt,
                             input bit mid_pulse);
    int c = 0;
    bit seen = 1'b0;
    logic [31:0] smask;
    while (c < 200 && !seen) begin
      @(negedge clk);
      c++;
      if (mid_pulse && c == 8) begin
        start = 1'b1;
        is_ir = ~ir;
        len   = LEN_W'(1);
        data  = 8'h00;
      end else if (mid_pulse && c == 9) begin
        start = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    smask = (32'h1 << exp_slots) - 32'h1;
    check({name, " latency"}, c, exp_lat);
    check({name, " done-cycle busy/tck/tms"}, {busy, tck, tms}, 3'b000);
    check({name, " o_data"}, rdata, exp_data);
    check({name, " slot count"}, slot_cnt - s0, exp_slots);
    check({name, " tms sequence"}, tms_log & smask, exp_tms);
    check({name, " target reg"}, ir ? tgt_ir : tgt_dr, exp_tgt);
    check({name, " tap in RTI"}, 32'(tap_q), 32'(RTI));
  endtask

  // Release reset at a negedge and measure the INIT sequence.
  task automatic release_and_init(input string name);
    int n = 0;
    rst_n = 1'b1;
    #1;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    check({name, " busy cycles"}, n, 12);
    check({name, " idle tck"}, tck, 1'b0);
    check({name, " slots"}, slot_cnt, 6);
    check({name, " tms sequence"}, tms_log[5:0], 6'b111110);
    check({name, " tap in RTI"}, 32'(tap_q), 32'(RTI));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             ir;
    logic [LEN_W-1:0] len;
    logic [7:0]       data;
    logic [7:0]       cap;
    int               tl;
    int               lat;
    int               slots;
    logic [31:0]      tms;
    logic [7:0]       exp_data;
    logic [7:0]       exp_tgt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  s0;
    bit  done_seen;

    //           ir    len       data   cap    tl lat slots tms        data   tgt
    vecs[0] = '{1'b1, 4'd4,  8'h0A, 8'hF5, 4, 20, 10, 32'h306,  8'h05, 8'h0A};
    vecs[1] = '{1'b0, 4'd8,  8'hA5, 8'h3C, 8, 26, 13, 32'h1006, 8'h3C, 8'hA5};
    vecs[2] = '{1'b0, 4'd0,  8'hFE, 8'hFF, 1, 12,  6, 32'h26,   8'h01, 8'h00};
    vecs[3] = '{1'b1, 4'd15, 8'h5C, 8'hC3, 8, 28, 14, 32'h3006, 8'hC3, 8'h5C};
    vecs[4] = '{1'b0, 4'd3,  8'hF6, 8'hFD, 3, 16,  8, 32'h86,   8'h05, 8'h06};

    // Reset values while reset is held.
    #12;
    check("reset tck/tms/tdi/busy/done", {tck, tms, tdi, busy, done}, 5'b01010);
    check("reset o_data", rdata, 8'h00);
    @(negedge clk);
    release_and_init("init");

    // Table-driven scans.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_scan(vecs[i].ir, vecs[i].len, vecs[i].data, vecs[i].cap, vecs[i].tl, s0);
      finish_scan($sformatf("vec%0d", i), s0, vecs[i].ir, vecs[i].lat, vecs[i].slots,
                  vecs[i].tms, vecs[i].exp_data, vecs[i].exp_tgt, 1'b0);
    end

    // Start pulsed mid-scan must be ignored; done is a single-cycle pulse.
    @(negedge clk);
    start_scan(1'b0, 4'd5, 8'h13, 8'h0A, 5, s0);
    finish_scan("midstart", s0, 1'b0, 20, 10, 32'h206, 8'h0A, 8'h13, 1'b1);
    @(negedge clk);
    check("midstart done pulse width / no extra scan", {done, busy}, 2'b00);

    // Back-to-back: second request presented in the done cycle.
    @(negedge clk);
    start_scan(1'b1, 4'd4, 8'h0A, 8'h05, 4, s0);
    finish_scan("b2b first", s0, 1'b1, 20, 10, 32'h306, 8'h05, 8'h0A, 1'b0);
    start_scan(1'b0, 4'd2, 8'h02, 8'h01, 2, s0);
    finish_scan("b2b second", s0, 1'b0, 14, 7, 32'h46, 8'h01, 8'h02, 1'b0);

    // Reset in the middle of SHIFT: outputs return to reset values at once,
    // no done pulse, INIT replays and the response register reads 0.
    @(negedge clk);
    start_scan(1'b0, 4'd8, 8'h81, 8'h7E, 8, s0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort reset outputs", {tck, tms, tdi, busy, done}, 5'b01010);
    check("abort o_data", rdata, 8'h00);
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    release_and_init("reinit");
    repeat (4) begin
      if (done) done_seen = 1'b1;
      @(negedge clk);
    end
    check("abort no done pulse", done_seen, 1'b0);
    check("abort o_data after init", rdata, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
